// File: rtl/focus_pkg.sv
// Shared constants, FSM encoding and pixel side-band flags for the focus-measure stage.
package focus_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned CNT_W     = 12;
    localparam int unsigned LUMA_LAT  = 2;
    localparam int unsigned PIPE_LAT  = 4;
    localparam int unsigned SUM_W_DEF = 32;

    localparam logic [PIX_W-1:0] COEF_R = 8'd77;
    localparam logic [PIX_W-1:0] COEF_G = 8'd150;
    localparam logic [PIX_W-1:0] COEF_B = 8'd29;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        ACCUM = 2'd2,
        LATCH = 2'd3
    } state_t;

    // Side-band travelling with each pixel through the luma pipeline.
    typedef struct packed {
        logic win;
        logic first;
    } pix_flags_t;

endpackage

// File: rtl/focus_luma.sv
// RGB to 8-bit luma, two register stages (products, then sum) with matching flag delay.
module focus_luma
    import focus_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] r,
    input  logic [PIX_W-1:0] g,
    input  logic [PIX_W-1:0] b,
    input  pix_flags_t       flags_in,
    output logic [PIX_W-1:0] y,
    output pix_flags_t       flags_out
);

    logic [15:0] prod_r;
    logic [15:0] prod_g;
    logic [15:0] prod_b;
    logic [15:0] sum_c;
    pix_flags_t  fl_q [LUMA_LAT];

    // Coefficients sum to 256, so the 16-bit sum cannot overflow.
    assign sum_c = prod_r + prod_g + prod_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r <= '0;
            prod_g <= '0;
            prod_b <= '0;
            y      <= '0;
            for (int unsigned i = 0; i < LUMA_LAT; i++) begin
                fl_q[i] <= '0;
            end
        end else begin
            prod_r  <= 16'(r) * 16'(COEF_R);
            prod_g  <= 16'(g) * 16'(COEF_G);
            prod_b  <= 16'(b) * 16'(COEF_B);
            y       <= PIX_W'(sum_c >> 8);
            fl_q[0] <= flags_in;
            for (int unsigned i = 1; i < LUMA_LAT; i++) begin
                fl_q[i] <= fl_q[i-1];
            end
        end
    end

    assign flags_out = fl_q[LUMA_LAT-1];

endmodule

// File: rtl/focus_win_stat.sv
// Windowed, cored horizontal-gradient focus measure latched once per frame.
// Optional window-border overlay flag built only when FOCUS_WIN_MARK_EN is defined.
module focus_win_stat
    import focus_pkg::*;
#(
    parameter int unsigned WIN_X0 = 160,
    parameter int unsigned WIN_Y0 = 120,
    parameter int unsigned WIN_W  = 480,
    parameter int unsigned WIN_H  = 360,
    parameter int unsigned THRESH = 8,
    parameter int unsigned SUM_W  = SUM_W_DEF
) (
    input  logic             VIDEO_CLK,
    input  logic             RESET_N,
    input  logic             VIDEO_VS,
    input  logic             VIDEO_HS,
    input  logic             VIDEO_DE,
    input  logic [PIX_W-1:0] iR,
    input  logic [PIX_W-1:0] iG,
    input  logic [PIX_W-1:0] iB,
    output logic [SUM_W-1:0] FOC_SUM,
    output logic             FOC_VALID,
    output logic             FOC_PART,
    output logic             WIN_MARK
);

    localparam logic [CNT_W-1:0] X_LO  = CNT_W'(WIN_X0);
    localparam logic [CNT_W-1:0] X_HI  = CNT_W'(WIN_X0 + WIN_W - 1);
    localparam logic [CNT_W-1:0] Y_LO  = CNT_W'(WIN_Y0);
    localparam logic [CNT_W-1:0] Y_HI  = CNT_W'(WIN_Y0 + WIN_H - 1);
    localparam logic [CNT_W-1:0] Y_END = CNT_W'(WIN_Y0 + WIN_H);

    logic             vs_r, vs_rr, hs_r, hs_rr, de_r, de_rr;
    logic [PIX_W-1:0] r_r, g_r, b_r;
    logic             vs_fall, hs_fall, de_fall;
    logic [CNT_W-1:0] col, line, line_max;
    logic             in_win, first_c;
    pix_flags_t       fl_in, fl_y;
    logic [PIX_W-1:0] y, y_prev, grad_c, core;
    logic             win3;
    logic [SUM_W:0]   acc_add;
    logic [SUM_W-1:0] acc, acc_sat;
    state_t           state;
    logic [1:0]       lat_cnt;

    // Single input register stage; edges are seen between the two copies.
    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            {vs_r, vs_rr, hs_r, hs_rr, de_r, de_rr} <= '0;
            r_r <= '0;
            g_r <= '0;
            b_r <= '0;
        end else begin
            vs_r  <= VIDEO_VS;
            vs_rr <= vs_r;
            hs_r  <= VIDEO_HS;
            hs_rr <= hs_r;
            de_r  <= VIDEO_DE;
            de_rr <= de_r;
            r_r   <= iR;
            g_r   <= iG;
            b_r   <= iB;
        end
    end

    assign vs_fall = vs_rr & ~vs_r;
    assign hs_fall = hs_rr & ~hs_r;
    assign de_fall = de_rr & ~de_r;

    // Column/line position of the pixel currently in the input register; saturating.
    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            col  <= '0;
            line <= '0;
        end else begin
            if (hs_fall) begin
                col <= '0;
            end else if (de_r && (col != '1)) begin
                col <= col + 1'b1;
            end
            if (vs_fall) begin
                line <= '0;
            end else if (de_fall && (line != '1)) begin
                line <= line + 1'b1;
            end
        end
    end

    assign in_win  = de_r && (col >= X_LO) && (col <= X_HI) && (line >= Y_LO) && (line <= Y_HI);
    assign first_c = in_win && (col == X_LO);
    assign fl_in   = '{win: in_win, first: first_c};

    focus_luma u_luma (
        .clk       (VIDEO_CLK),
        .rst_n     (RESET_N),
        .r         (r_r),
        .g         (g_r),
        .b         (b_r),
        .flags_in  (fl_in),
        .y         (y),
        .flags_out (fl_y)
    );

    assign grad_c = (y >= y_prev) ? (y - y_prev) : (y_prev - y);

    // Gradient and coring stage; first window pixel of a line has no left neighbour.
    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            y_prev <= '0;
            core   <= '0;
            win3   <= 1'b0;
        end else begin
            win3 <= fl_y.win;
            if (fl_y.win) begin
                y_prev <= y;
            end
            core <= (fl_y.win && !fl_y.first && (grad_c > PIX_W'(THRESH))) ? grad_c : '0;
        end
    end

    assign acc_add = {1'b0, acc} + (SUM_W+1)'(core);
    assign acc_sat = acc_add[SUM_W] ? '1 : acc_add[SUM_W-1:0];

    // Frame FSM: accumulate, then drain the pipeline for PIPE_LAT cycles before latching.
    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            acc       <= '0;
            lat_cnt   <= '0;
            line_max  <= '0;
            FOC_SUM   <= '0;
            FOC_VALID <= 1'b0;
            FOC_PART  <= 1'b0;
        end else begin
            FOC_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (vs_fall) begin
                        state <= SYNC;
                    end
                end
                SYNC: begin
                    acc   <= '0;
                    state <= ACCUM;
                end
                ACCUM: begin
                    if (win3) begin
                        acc <= acc_sat;
                    end
                    if (vs_fall) begin
                        line_max <= line;
                        lat_cnt  <= '0;
                        state    <= LATCH;
                    end
                end
                LATCH: begin
                    if (lat_cnt == 2'(PIPE_LAT - 1)) begin
                        FOC_SUM   <= acc;
                        FOC_VALID <= 1'b1;
                        FOC_PART  <= (line_max < Y_END);
                        acc       <= '0;
                        state     <= ACCUM;
                    end else begin
                        if (win3) begin
                            acc <= acc_sat;
                        end
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FOCUS_WIN_MARK_EN
    logic border_c;

    assign border_c = (col == X_LO) || (col == X_HI) || (line == Y_LO) || (line == Y_HI);

    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            WIN_MARK <= 1'b0;
        end else begin
            WIN_MARK <= in_win && border_c;
        end
    end
`else
    assign WIN_MARK = 1'b0;
`endif

endmodule
